// File: rtl/fwrisc_trap_seq_pkg.sv
// Shared fwrisc trap-sequencer definitions: CSR write addresses, sequencer
// state encoding and the MSTATUS update rules for trap entry and MRET.
package fwrisc_trap_seq_pkg;

    localparam logic [5:0] CSR_MSTATUS = 6'h00;
    localparam logic [5:0] CSR_MEPC    = 6'h01;
    localparam logic [5:0] CSR_MCAUSE  = 6'h02;
    localparam logic [5:0] CSR_MTVAL   = 6'h03;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_W_MEPC,
        ST_W_MTVAL,
        ST_W_MCAUSE,
        ST_W_MSTATUS,
        ST_W_RET
    } trap_state_e;

    // Trap entry: MPIE takes the old MIE, MIE is cleared
    function automatic logic [31:0] mstatus_on_trap(input logic [31:0] m);
        logic [31:0] r;
        r    = m;
        r[7] = m[3];
        r[3] = 1'b0;
        return r;
    endfunction

    // MRET: MIE takes the old MPIE, MPIE is set
    function automatic logic [31:0] mstatus_on_ret(input logic [31:0] m);
        logic [31:0] r;
        r    = m;
        r[3] = m[7];
        r[7] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/fwrisc_trap_seq_if.sv
// Core <-> trap sequencer bundle: trap/MRET request handshake, CSR state
// inputs, CSR write port and PC redirect.
interface fwrisc_trap_seq_if #(
    parameter int NUM_IRQ = 3
);
    logic               instr_boundary;
    logic               exc_req;
    logic [4:0]         exc_cause;
    logic [31:0]        exc_tval;
    logic [31:0]        exc_pc;
    logic [NUM_IRQ-1:0] irq;
    logic [NUM_IRQ-1:0] irq_en;
    logic [31:0]        mstatus;
    logic [31:0]        mtvec;
    logic [31:0]        mepc;
    logic               mret_req;
    logic               exc_ack;
    logic               busy;
    logic [5:0]         csr_waddr;
    logic [31:0]        csr_wdata;
    logic               csr_wen;
    logic               trap_valid;
    logic [31:0]        trap_pc;
    logic               trap_is_ret;

    modport master (
        output instr_boundary, exc_req, exc_cause, exc_tval, exc_pc,
               irq, irq_en, mstatus, mtvec, mepc, mret_req,
        input  exc_ack, busy, csr_waddr, csr_wdata, csr_wen,
               trap_valid, trap_pc, trap_is_ret
    );

    modport slave (
        input  instr_boundary, exc_req, exc_cause, exc_tval, exc_pc,
               irq, irq_en, mstatus, mtvec, mepc, mret_req,
        output exc_ack, busy, csr_waddr, csr_wdata, csr_wen,
               trap_valid, trap_pc, trap_is_ret
    );
endinterface

// File: rtl/fwrisc_irq_prio.sv
// Lowest-index-wins priority encoder for the interrupt request lines.
module fwrisc_irq_prio #(
    parameter int NUM_IRQ = 3
) (
    input  logic [NUM_IRQ-1:0] req,
    output logic               valid,
    output logic [3:0]         index
);

    // Scan downward so the lowest set line is the last (winning) assignment
    always_comb begin
        valid = 1'b0;
        index = '0;
        for (int unsigned i = NUM_IRQ; i > 0; i--) begin
            if (req[i-1]) begin
                valid = 1'b1;
                index = 4'(i - 1);
            end
        end
    end

endmodule

// File: rtl/fwrisc_trap_seq.sv
// Trap/MRET sequencer: accepts an exception, interrupt or MRET in IDLE and
// sequences the machine-mode CSR updates and PC redirect.
module fwrisc_trap_seq
    import fwrisc_trap_seq_pkg::*;
#(
    parameter int NUM_IRQ        = 3,
    parameter int IRQ_CAUSE_BASE = 11,
    parameter int VECTORED       = 1
) (
    input logic          clock,
    input logic          reset,
    fwrisc_trap_seq_if.slave bus
);

    trap_state_e        state, state_n;
    logic [NUM_IRQ-1:0] irq_pend;
    logic               irq_valid;
    logic [3:0]         irq_index;
    logic               take_exc, take_irq, take_ret;
    logic [4:0]         irq_cause;

    logic [31:0]        pc_q, tval_q, mstatus_q;
    logic [4:0]         cause_q;
    logic               int_q;
    logic [31:0]        vec_base;

    assign irq_pend = bus.irq & bus.irq_en & {NUM_IRQ{bus.mstatus[3]}};

    fwrisc_irq_prio #(.NUM_IRQ(NUM_IRQ)) u_prio (
        .req   (irq_pend),
        .valid (irq_valid),
        .index (irq_index)
    );

    assign irq_cause = 5'(IRQ_CAUSE_BASE) + {1'b0, irq_index};
    assign take_exc  = (state == ST_IDLE) && bus.exc_req;
    assign take_irq  = (state == ST_IDLE) && !bus.exc_req && bus.instr_boundary && irq_valid;
    assign take_ret  = (state == ST_IDLE) && !bus.exc_req && bus.instr_boundary
                       && !irq_valid && bus.mret_req;
    assign vec_base  = bus.mtvec & ~32'h3;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            pc_q      <= '0;
            tval_q    <= '0;
            cause_q   <= '0;
            int_q     <= 1'b0;
            mstatus_q <= '0;
        end else begin
            state <= state_n;
            if (take_exc || take_irq || take_ret) begin
                pc_q      <= bus.exc_pc;
                tval_q    <= take_exc ? bus.exc_tval : '0;
                cause_q   <= take_exc ? bus.exc_cause : irq_cause;
                int_q     <= take_irq;
                mstatus_q <= bus.mstatus;
            end
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: begin
                if (take_exc || take_irq) state_n = ST_W_MEPC;
                else if (take_ret)        state_n = ST_W_RET;
            end
            ST_W_MEPC:    state_n = ST_W_MTVAL;
            ST_W_MTVAL:   state_n = ST_W_MCAUSE;
            ST_W_MCAUSE:  state_n = ST_W_MSTATUS;
            ST_W_MSTATUS: state_n = ST_IDLE;
            ST_W_RET:     state_n = ST_IDLE;
            default:      state_n = ST_IDLE;
        endcase
    end

    // Outputs are gated by reset so an aborted sequence emits nothing further
    always_comb begin
        bus.exc_ack     = !reset && (take_exc || take_irq || take_ret);
        bus.busy        = !reset && (state != ST_IDLE);
        bus.csr_wen     = 1'b0;
        bus.csr_waddr   = '0;
        bus.csr_wdata   = '0;
        bus.trap_valid  = 1'b0;
        bus.trap_pc     = '0;
        bus.trap_is_ret = 1'b0;
        if (!reset) begin
            case (state)
                ST_W_MEPC: begin
                    bus.csr_wen   = 1'b1;
                    bus.csr_waddr = CSR_MEPC;
                    bus.csr_wdata = pc_q;
                end
                ST_W_MTVAL: begin
                    bus.csr_wen   = 1'b1;
                    bus.csr_waddr = CSR_MTVAL;
                    bus.csr_wdata = tval_q;
                end
                ST_W_MCAUSE: begin
                    bus.csr_wen   = 1'b1;
                    bus.csr_waddr = CSR_MCAUSE;
                    bus.csr_wdata = {int_q, 26'b0, cause_q};
                end
                ST_W_MSTATUS: begin
                    bus.csr_wen    = 1'b1;
                    bus.csr_waddr  = CSR_MSTATUS;
                    bus.csr_wdata  = mstatus_on_trap(mstatus_q);
                    bus.trap_valid = 1'b1;
                    if ((VECTORED != 0) && (bus.mtvec[1:0] == 2'b01) && int_q)
                        bus.trap_pc = vec_base + {25'b0, cause_q, 2'b00};
                    else
                        bus.trap_pc = vec_base;
                end
                ST_W_RET: begin
                    bus.csr_wen     = 1'b1;
                    bus.csr_waddr   = CSR_MSTATUS;
                    bus.csr_wdata   = mstatus_on_ret(mstatus_q);
                    bus.trap_valid  = 1'b1;
                    bus.trap_is_ret = 1'b1;
                    bus.trap_pc     = bus.mepc & ~32'h1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/fwrisc_trap_seq.md
FWRISC_TRAP_SEQ -- requirements
Module: fwrisc_trap_seq

Interface
REQ-001 Parameter NUM_IRQ, default 3: number of interrupt lines, legal range 1..16.
REQ-002 Parameter IRQ_CAUSE_BASE, default 11: cause code of irq[0]; IRQ_CAUSE_BASE+NUM_IRQ-1 SHALL be <= 31.
REQ-003 Parameter VECTORED, default 1: enables vectored interrupt entry.
REQ-004 clock  in  1  clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 instr_boundary  in  1  core at instruction boundary; traps may be taken.
REQ-007 exc_req  in  1  synchronous exception request, level, held until exc_ack.
REQ-008 exc_cause  in  5  exception cause code.
REQ-009 exc_tval  in  32  value for MTVAL.
REQ-010 exc_pc  in  32  PC of the faulting or interrupted instruction.
REQ-011 irq  in  NUM_IRQ  level interrupt lines.
REQ-012 irq_en  in  NUM_IRQ  per-line enables (mie bits).
REQ-013 mstatus  in  32  current MSTATUS; bit 3 MIE, bit 7 MPIE.
REQ-014 mtvec  in  32  trap vector; bits [1:0] give the mode.
REQ-015 mepc  in  32  current MEPC.
REQ-016 mret_req  in  1  MRET request, level, held until exc_ack.
REQ-017 exc_ack  out  1  one-cycle pulse on acceptance of an exception, interrupt or MRET.
REQ-018 busy  out  1  high while the sequencer is not in IDLE.
REQ-019 csr_waddr  out  6  CSR write address.
REQ-020 csr_wdata  out  32  CSR write data.
REQ-021 csr_wen  out  1  CSR write strobe.
REQ-022 trap_valid  out  1  one-cycle pulse; redirect the PC to trap_pc.
REQ-023 trap_pc  out  32  redirect target; valid only with trap_valid.
REQ-024 trap_is_ret  out  1  qualifies trap_valid as an MRET return.

Function
REQ-025 Request acceptance SHALL occur only in IDLE.
- Exception: accepted whenever exc_req=1.
- Interrupt or MRET: accepted only when instr_boundary=1.
REQ-026 Acceptance priority SHALL be exc_req, then a pending interrupt, then mret_req.
- Pending interrupt: any irq&irq_en bit set with mstatus[3]=1.
REQ-027 Among pending interrupts, the lowest index SHALL win; cause = IRQ_CAUSE_BASE+index, interrupt flag set.
REQ-028 On acceptance, exc_pc, exc_tval (0 for interrupts), cause, interrupt flag and mstatus SHALL be captured, and exc_ack SHALL pulse.
REQ-029 Trap sequence, accepted at cycle N; states IDLE -> W_MEPC -> W_MTVAL -> W_MCAUSE -> W_MSTATUS -> IDLE.
- N+1: csr_wen=1, CSR_MEPC <= pc.
- N+2: CSR_MTVAL <= tval.
- N+3: CSR_MCAUSE <= {int, 26'b0, cause[4:0]}.
- N+4: CSR_MSTATUS <= captured value with MPIE=old MIE, MIE=0; trap_valid=1 in the same cycle.
REQ-030 trap_pc SHALL equal {mtvec[31:2],2'b00} + 4*cause when VECTORED=1, mtvec[1:0]=2'b01 and the trap is an interrupt; otherwise {mtvec[31:2],2'b00}.
REQ-031 MRET sequence, accepted at cycle N; states IDLE -> W_RET -> IDLE.
- N+1: CSR_MSTATUS <= MIE=old MPIE, MPIE=1.
- N+1: trap_valid=1, trap_is_ret=1, trap_pc={mepc[31:1],1'b0}.
REQ-032 Requests arriving while busy SHALL be ignored; exc_ack SHALL NOT pulse for them.
REQ-033 csr_wen SHALL be 0 in IDLE; csr_waddr and csr_wdata are don't-care when csr_wen=0.
REQ-034 Interrupt lines SHALL NOT be re-sampled after acceptance; deassertion mid-sequence SHALL NOT alter it.

Reset
REQ-035 Reset SHALL force IDLE, exc_ack=0, busy=0, csr_wen=0, trap_valid=0, trap_is_ret=0, and clear all captured registers.
REQ-036 Reset mid-sequence SHALL abort it; no further CSR writes and no trap_valid SHALL follow.

Structure
REQ-037 CSR address constants (CSR_MEPC, CSR_MTVAL, CSR_MCAUSE, CSR_MSTATUS) and the state encoding SHALL come from the shared fwrisc package/header, not be redefined locally.
REQ-038 A sub-module fwrisc_irq_prio SHALL implement the parametrised lowest-index priority encoder (NUM_IRQ in; valid and index out).

Verification
REQ-039 exc_req, cause=4, tval=0x1003, pc=0x80000010, mtvec=0x80000101 -> writes MEPC=0x80000010, MTVAL=0x1003, MCAUSE=0x4, MSTATUS MIE 1->0 on cycles N+1..N+4; trap_pc=0x80000100.
REQ-040 irq=3'b110, irq_en=3'b111, MIE=1, boundary=1, VECTORED, mtvec=0x80000101 -> cause 12, MCAUSE=0x8000000C, trap_pc=0x80000130.
REQ-041 irq=3'b001 with MIE=0, or irq_en=0 -> no exc_ack, no csr_wen for 10 cycles.
REQ-042 exc_req and irq and mret_req asserted together -> exception taken; MCAUSE interrupt flag 0.
REQ-043 MRET with mepc=0x80000021, mstatus MPIE=1 -> MSTATUS MIE=1; trap_pc=0x80000020 at N+1 with trap_is_ret=1.
REQ-044 reset asserted at N+2 of a trap -> no MCAUSE write, no trap_valid; a fresh request after reset completes normally.
